// File: rtl/approx_mac_if.sv
// Stream bus of the approximate MAC: operand beats in, saturated packet sums out.
// The unit sits on the slave side; the operand streamer and activation stage take the master side.
interface approx_mac_if #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 2*WIDTH+4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_x;
  logic [WIDTH-1:0]     in_y;
  logic                 in_approx;
  logic                 in_first;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_data;
  logic                 out_ovf;

  modport master (
    output in_valid, in_x, in_y, in_approx, in_first, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_x, in_y, in_approx, in_first, in_last, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/approx_mac_pipe.sv
// Three-stage unsigned MAC: operand register, exact/approximate product, saturating
// packet accumulator with a stall-held result register and valid/ready flow control.
module approx_mac_pipe #(
  parameter int WIDTH     = 8,
  parameter int APPROX_K  = 8,
  parameter int ACC_WIDTH = 2*WIDTH+4
) (
  input  logic         clk,
  input  logic         rst,
  approx_mac_if.slave  bus
);
  localparam int PW = 2*WIDTH;
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = '1;

  logic                 stall;

  logic                 s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]     s1_x_q, s1_x_d;
  logic [WIDTH-1:0]     s1_y_q, s1_y_d;
  logic                 s1_approx_q, s1_approx_d;
  logic                 s1_first_q, s1_first_d;
  logic                 s1_last_q, s1_last_d;

  logic                 s2_valid_q, s2_valid_d;
  logic [PW-1:0]        s2_prod_q, s2_prod_d;
  logic                 s2_first_q, s2_first_d;
  logic                 s2_last_q, s2_last_d;

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic                 out_valid_q, out_valid_d;
  logic [ACC_WIDTH-1:0] out_data_q, out_data_d;
  logic                 out_ovf_q, out_ovf_d;

  logic [PW-1:0]        prod_exact, prod_hi, prod_lo, prod_apx, pp_term, prod_sel;
  logic [ACC_WIDTH:0]   prod_ext, sum;
  logic [ACC_WIDTH-1:0] acc_next;
  logic                 ovf_next, ovf_base;

  assign stall         = out_valid_q & ~bus.out_ready;
  assign bus.in_ready  = ~stall;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ovf   = out_ovf_q;

  // Columns below APPROX_K are OR-reduced without carries; above it the pp bits add normally.
  always_comb begin
    prod_exact = {{WIDTH{1'b0}}, s1_x_q} * {{WIDTH{1'b0}}, s1_y_q};
    prod_hi    = '0;
    prod_lo    = '0;
    pp_term    = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      for (int unsigned j = 0; j < WIDTH; j++) begin
        pp_term = {{(PW-1){1'b0}}, s1_x_q[i] & s1_y_q[j]} << (i + j);
        if (int'(i + j) >= APPROX_K)
          prod_hi = prod_hi + pp_term;
        else
          prod_lo = prod_lo | pp_term;
      end
    end
    // prod_hi is a multiple of 2^APPROX_K and prod_lo lies below it, so OR is the sum.
    prod_apx = prod_hi | prod_lo;
    prod_sel = s1_approx_q ? prod_apx : prod_exact;
  end

  always_comb begin
    prod_ext = {{(ACC_WIDTH+1-PW){1'b0}}, s2_prod_q};
    sum      = s2_first_q ? prod_ext : ({1'b0, acc_q} + prod_ext);
    ovf_base = s2_first_q ? 1'b0 : ovf_q;
    if (sum > {1'b0, ACC_MAX}) begin
      acc_next = ACC_MAX;
      ovf_next = 1'b1;
    end else begin
      acc_next = sum[ACC_WIDTH-1:0];
      ovf_next = ovf_base;
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_x_d      = s1_x_q;
    s1_y_d      = s1_y_q;
    s1_approx_d = s1_approx_q;
    s1_first_d  = s1_first_q;
    s1_last_d   = s1_last_q;
    s2_valid_d  = s2_valid_q;
    s2_prod_d   = s2_prod_q;
    s2_first_d  = s2_first_q;
    s2_last_d   = s2_last_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    if (!stall) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_x_d      = bus.in_x;
        s1_y_d      = bus.in_y;
        s1_approx_d = bus.in_approx;
        s1_first_d  = bus.in_first;
        s1_last_d   = bus.in_last;
      end
      s2_valid_d = s1_valid_q;
      s2_prod_d  = prod_sel;
      s2_first_d = s1_first_q;
      s2_last_d  = s1_last_q;
      if (s2_valid_q) begin
        acc_d = acc_next;
        ovf_d = ovf_next;
      end
      // Not stalled means any pending result is being taken now, so valid follows the new last beat.
      out_valid_d = s2_valid_q & s2_last_q;
      if (s2_valid_q && s2_last_q) begin
        out_data_d = acc_next;
        out_ovf_d  = ovf_next;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_x_q      <= '0;
      s1_y_q      <= '0;
      s1_approx_q <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_prod_q   <= '0;
      s2_first_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_x_q      <= s1_x_d;
      s1_y_q      <= s1_y_d;
      s1_approx_q <= s1_approx_d;
      s1_first_q  <= s1_first_d;
      s1_last_q   <= s1_last_d;
      s2_valid_q  <= s2_valid_d;
      s2_prod_q   <= s2_prod_d;
      s2_first_q  <= s2_first_d;
      s2_last_q   <= s2_last_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end
endmodule

// File: tb/tb_approx_mac_pipe.sv
// Directed bench for approx_mac_pipe: a driver pushes hand-computed packet results into a
// queue, and a negedge monitor pops and compares them on every output handshake.
module tb_approx_mac_pipe;
  typedef struct packed {
    logic [19:0] data;
    logic        ovf;
  } exp_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  exp_t exp_q[$];
  logic        holding;
  logic [19:0] hold_data;
  logic        hold_ovf;

  approx_mac_if #(.WIDTH(8), .ACC_WIDTH(20)) bus ();

  approx_mac_pipe #(.WIDTH(8), .APPROX_K(8), .ACC_WIDTH(20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // Presents one beat starting at posedge+1; returns at posedge+1 after it was accepted.
  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic a,
                      input logic f, input logic l,
                      input logic [19:0] exp_d, input logic exp_o);
    logic rdy;
    logic ok;
    exp_t e;
    ok = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_x      = x;
    bus.in_y      = y;
    bus.in_approx = a;
    bus.in_first  = f;
    bus.in_last   = l;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0 for 200 cycles required acceptance");
    end else if (l) begin
      e.data = exp_d;
      e.ovf  = exp_o;
      exp_q.push_back(e);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 200; c++) begin
      if (exp_q.size() == 0 && !bus.out_valid) return;
      @(posedge clk);
      #1;
    end
    n_tests++;
    n_fail++;
    $display("FAIL drain_timeout: got %0d results outstanding required 0", exp_q.size());
  endtask

  task automatic wait_out_valid();
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.out_valid) return;
    end
    n_tests++;
    n_fail++;
    $display("FAIL wait_valid_timeout: got out_valid=0 required 1 within 100 cycles");
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.out_valid) begin
      if (holding) begin
        check("stall_data_stable", bus.out_data, hold_data);
        check("stall_ovf_stable", bus.out_ovf, hold_ovf);
      end
      if (bus.out_ready) begin
        holding <= 1'b0;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_result: got out_data=%0d required no result", bus.out_data);
        end else begin
          e = exp_q.pop_front();
          check("result_data", bus.out_data, e.data);
          check("result_ovf", bus.out_ovf, e.ovf);
        end
      end else begin
        check("in_ready_stall", bus.in_ready, 1'b0);
        hold_data <= bus.out_data;
        hold_ovf  <= bus.out_ovf;
        holding   <= 1'b1;
      end
    end else begin
      holding <= 1'b0;
    end
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.in_approx = 1'b0;
    bus.in_first  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("reset_out_valid", bus.out_valid, 1'b0);
    check("reset_out_data", bus.out_data, 20'd0);
    check("reset_out_ovf", bus.out_ovf, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_in_ready", bus.in_ready, 1'b1);

    // Low columns only, with latency check on the approximate beat.
    send(8'd3, 8'd3, 1'b0, 1'b1, 1'b1, 20'd9, 1'b0);
    drain();
    send(8'd3, 8'd3, 1'b1, 1'b1, 1'b1, 20'd7, 1'b0);
    @(negedge clk);
    check("latency_edge1", bus.out_valid, 1'b0);
    @(negedge clk);
    check("latency_edge2", bus.out_valid, 1'b0);
    @(negedge clk);
    check("latency_edge3", bus.out_valid, 1'b1);
    @(posedge clk);
    #1;
    drain();

    // Mixed high and low columns.
    send(8'h81, 8'h81, 1'b0, 1'b1, 1'b1, 20'd16641, 1'b0);
    send(8'h81, 8'h81, 1'b1, 1'b1, 1'b1, 20'd16513, 1'b0);
    send(8'd255, 8'd1, 1'b0, 1'b1, 1'b1, 20'd255, 1'b0);
    send(8'd255, 8'd1, 1'b1, 1'b1, 1'b1, 20'd255, 1'b0);
    drain();

    // 17 * 65025 = 1105425 exceeds 2^20-1; the next packet restarts clean.
    for (int b = 1; b <= 17; b++)
      send(8'd255, 8'd255, 1'b0, b == 1, b == 17, 20'hFFFFF, 1'b1);
    send(8'd1, 8'd1, 1'b0, 1'b1, 1'b0, 20'd0, 1'b0);
    send(8'd1, 8'd1, 1'b0, 1'b0, 1'b1, 20'd2, 1'b0);
    drain();

    // Backpressure: out_ready low for 5 cycles after the first result appears.
    bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 1; i <= 6; i++)
          send(8'(i), 8'd1, 1'b0, 1'b1, 1'b1, 20'(i), 1'b0);
      end
      begin
        wait_out_valid();
        repeat (5) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();

    // Back-to-back single-beat packets with out_ready held high.
    fork
      begin
        for (int i = 10; i <= 15; i++)
          send(8'(i), 8'd2, 1'b0, 1'b1, 1'b1, 20'(2*i), 1'b0);
      end
      begin
        wait_out_valid();
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("b2b_out_valid", bus.out_valid, 1'b1);
        end
      end
    join
    drain();

    // Reset between beats 2 and 3 of a 4-beat packet.
    send(8'd100, 8'd100, 1'b0, 1'b1, 1'b0, 20'd0, 1'b0);
    send(8'd100, 8'd100, 1'b0, 1'b0, 1'b0, 20'd0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", bus.out_valid, 1'b0);
    check("midrst_out_data", bus.out_data, 20'd0);
    check("midrst_out_ovf", bus.out_ovf, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("midrst_in_ready", bus.in_ready, 1'b1);
    send(8'd2, 8'd5, 1'b0, 1'b1, 1'b1, 20'd10, 1'b0);
    drain();
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/approx_mac_pipe.md
# approx_mac_pipe

Parametrised, pipelined unsigned multiply-accumulate unit built around a configurable approximate partial-product array. It is the successor to the team's fixed 8x8 combinational approximate multipliers used in the LeNet accelerator. It adds an operand-width parameter, a tunable approximation boundary, a per-beat exact/approximate mode, packetised accumulation with saturation, and valid/ready flow control. It sits between the operand streamer and the activation stage of a convolution lane.

## Interface
- WIDTH, 8: operand width in bits (x and y unsigned).
- APPROX_K, 8: number of low product columns, 0 to 2*WIDTH, computed approximately. 0 means always exact.
- ACC_WIDTH, 2*WIDTH+4: accumulator and result width. Must be at least 2*WIDTH.
- clk input 1: rising-edge clock.
- rst input 1: asynchronous, active-high reset.
- in_valid input 1: input beat valid.
- in_ready output 1: unit can accept a beat.
- in_x input WIDTH: multiplicand.
- in_y input WIDTH: multiplier.
- in_approx input 1: 1 means use the approximate product for this beat; 0 means exact.
- in_first input 1: beat starts a new packet; the accumulator restarts.
- in_last input 1: beat ends the packet; a result is emitted.
- out_valid output 1: result valid.
- out_ready input 1: downstream accepts the result.
- out_data output ACC_WIDTH: saturated packet sum.
- out_ovf output 1: saturation occurred at some point in the packet.

## Operation
- **Partial products:** pp[i][j] = x[i] & y[j], placed in column c = i+j.
- **Exact product:** P = x*y.
- **Approximate product:**
  - Papx = sum of 2^(i+j) over all pp bits with i+j >= APPROX_K, added with full carry.
  - Plus, for each column c < APPROX_K: 2^c * (OR of all pp bits in column c).
  - Low columns generate no carries. Papx is always <= P, and is exact when at most one pp bit is set per low column.
- **Pipeline stages:**
  - S1 registers x, y, approx, first, last and the valid bit.
  - S2 registers the selected product (2*WIDTH bits) with its control bits.
  - S3 performs the accumulation.
- **Accumulation in S3:**
  - If first: sum = prod, and ovf restarts at 0.
  - Otherwise: sum = acc + prod.
  - If sum > 2^ACC_WIDTH-1: acc = 2^ACC_WIDTH-1 and ovf is set. ovf is sticky until the next first.
  - Once saturated, further beats keep acc at the maximum.
- **Result emission:** on a last beat in S3, out_data and out_ovf load the new acc and ovf values, and out_valid is set.
- **Beats before any first:** these accumulate onto the current acc (0 after reset).
- **Stall rule:** stall = out_valid & ~out_ready. While stalled, S1, S2, S3 and acc all hold and in_ready = 0. Otherwise in_ready = 1, and bubbles advance like beats.
- **Output clear:** out_valid clears on an out_ready handshake unless a new last beat completes S3 on the same edge; in that case out_valid stays 1 with the new data.
- **Reset:**
  - All stage valids = 0.
  - acc = 0, ovf = 0, out_data = 0, out_ovf = 0, out_valid = 0.
  - in_ready = 1 after reset releases.
  - A packet in flight when reset asserts is discarded; no partial result is emitted.

## Timing
- A beat accepted at edge E0 reaches S2 at E1 and is accumulated at E2. For a last beat, out_valid is high after E2, a latency of 3 edges.
- Throughput is one beat per cycle with no stall.
- Back-to-back packets are allowed: a first beat may immediately follow a last beat with no bubble.
- in_ready depends combinationally on out_valid and out_ready only. It does not depend on in_valid.
- in_approx, in_first and in_last are sampled only on an accepted beat. Inputs are ignored when in_valid = 0.
- out_data and out_ovf stay stable while out_valid = 1 and out_ready = 0.

## Test plan
- **Exact vs approximate, low columns**
  - Stimulus: WIDTH=8, APPROX_K=8; single beat (first=last=1), x=3, y=3.
  - Required: approx=0 gives out_data=9; approx=1 gives 7, out_ovf=0, out_valid 3 edges after acceptance.
- **Mixed high and low columns**
  - Stimulus: x=0x81, y=0x81.
  - Required: approx=0 gives 16641; approx=1 gives 16513. With x=255, y=1 both modes give 255.
- **Accumulation and saturation**
  - Stimulus: ACC_WIDTH=20; 17 exact beats of 255*255, first on beat 1 only, last on beat 17.
  - Required: out_data=1048575, out_ovf=1.
  - Follow-up: next packet of 2 beats of 1*1 gives out_data=2, out_ovf=0.
- **Backpressure**
  - Stimulus: packets of 1 beat each (x=i, y=1, i=1..6) streamed continuously; out_ready held 0 for 5 cycles, then 1.
  - Required: in_ready drops the cycle after out_valid rises; no result lost or duplicated; outputs arrive in order 1..6; out_data stable while stalled.
- **Simultaneous handshake and new result**
  - Stimulus: out_ready=1 continuously, back-to-back single-beat packets.
  - Required: out_valid stays 1 every cycle and out_data updates every edge.
- **Reset mid-packet**
  - Stimulus: assert rst asynchronously between beats 2 and 3 of a 4-beat packet.
  - Required: all outputs go 0 immediately; after release, a packet x=2, y=5 (single beat) gives 10.
